// File: rtl/gray_counter.sv
// gray_counter: synchronous up/down binary counter with a registered Gray
// copy, plus an independent two-stage Gray-to-binary decoder pipeline.
// Optional build macro GRAY_COUNTER_SAT_EN turns the wrapping counter into a
// saturating one; wrap then flags each enabled step blocked at a limit.
`timescale 1ns/1ps

module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap,
    input  logic [WIDTH-1:0] gin,
    input  logic             gin_vld,
    output logic [WIDTH-1:0] gdec,
    output logic             gdec_vld
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             at_limit;
    logic [WIDTH-1:0] step_bin;
    logic [WIDTH-1:0] step_gray;
    logic [WIDTH-1:0] load_gray;
    logic [WIDTH-1:0] s1_gin;
    logic             s1_vld;
    logic [WIDTH-1:0] s1_dec;

    // Next counter value for an enabled step; Gray is derived from the next
    // binary value so it lands on the same edge as bin.
    always_comb begin
        at_limit = up ? (bin == ALL_ONES) : (bin == '0);
`ifdef GRAY_COUNTER_SAT_EN
        step_bin = at_limit ? bin : (up ? (bin + ONE) : (bin - ONE));
`else
        step_bin = up ? (bin + ONE) : (bin - ONE);
`endif
        step_gray = step_bin ^ (step_bin >> 1);
        load_gray = load_val ^ (load_val >> 1);
    end

    // Counter register: reset beats load, load beats enable, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin  <= '0;
            gray <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            bin  <= load_val;
            gray <= load_gray;
            wrap <= 1'b0;
        end else if (en) begin
            bin  <= step_bin;
            gray <= step_gray;
            wrap <= at_limit;
        end else begin
            wrap <= 1'b0;
        end
    end

    // Decoder stage 1: capture the incoming Gray word only when it is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_gin <= '0;
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= gin_vld;
            if (gin_vld) begin
                s1_gin <= gin;
            end
        end
    end

    // Each decoded bit is the XOR of the Gray bits at and above its position.
    always_comb begin
        s1_dec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s1_dec[i] = ^(s1_gin >> i);
        end
    end

    // Decoder stage 2: register the decoded word and follow stage-1 valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            gdec     <= '0;
            gdec_vld <= 1'b0;
        end else begin
            gdec_vld <= s1_vld;
            if (s1_vld) begin
                gdec <= s1_dec;
            end
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: scoreboard bench for gray_counter (WIDTH=4).
// Counter expectations come from a behavioural model, decoder expectations
// are queued with their due edge; honours GRAY_COUNTER_SAT_EN when defined.
`timescale 1ns/1ps

module tb_gray_counter;

    localparam int WIDTH = 4;
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
`ifdef GRAY_COUNTER_SAT_EN
    localparam int TABLE_STEPS = 15;
`else
    localparam int TABLE_STEPS = 16;
`endif

    logic             clk;
    logic             rst;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] gray;
    logic             wrap;
    logic [WIDTH-1:0] gin;
    logic             gin_vld;
    logic [WIDTH-1:0] gdec;
    logic             gdec_vld;

    int tests_run    = 0;
    int tests_failed = 0;
    int edge_count   = 0;

    logic [WIDTH-1:0] m_bin;
    logic             m_wrap;

    typedef struct {
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] g;
        logic             w;
    } cnt_exp_t;

    typedef struct {
        int               due;
        logic [WIDTH-1:0] d;
    } dec_exp_t;

    cnt_exp_t cnt_q[$];
    dec_exp_t dec_q[$];

    logic [WIDTH-1:0] gray_seq [0:16];

    gray_counter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .bin      (bin),
        .gray     (gray),
        .wrap     (wrap),
        .gin      (gin),
        .gin_vld  (gin_vld),
        .gdec     (gdec),
        .gdec_vld (gdec_vld)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference Gray encoding: each bit flags a change between neighbours.
    function automatic logic [WIDTH-1:0] toGray(input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] g;
        g[WIDTH-1] = b[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            g[i] = b[i+1] ^ b[i];
        end
        return g;
    endfunction

    // Reference Gray decoding, walking down from the MSB.
    function automatic logic [WIDTH-1:0] grayToBin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Behavioural counter model, updated as stimulus is driven.
    task automatic modelCounter(input logic r, input logic e, input logic u,
                                input logic l, input logic [WIDTH-1:0] lv);
        if (r) begin
            m_bin  = '0;
            m_wrap = 1'b0;
        end else if (l) begin
            m_bin  = lv;
            m_wrap = 1'b0;
        end else if (e) begin
`ifdef GRAY_COUNTER_SAT_EN
            if ((u && m_bin == ALL_ONES) || (!u && m_bin == '0)) begin
                m_wrap = 1'b1;
            end else begin
                m_wrap = 1'b0;
                m_bin  = u ? m_bin + 1'b1 : m_bin - 1'b1;
            end
`else
            m_wrap = u ? (m_bin == ALL_ONES) : (m_bin == '0);
            m_bin  = u ? m_bin + 1'b1 : m_bin - 1'b1;
`endif
        end else begin
            m_wrap = 1'b0;
        end
    endtask

    // Pop the counter expectation for this edge and compare it.
    task automatic checkCounter();
        cnt_exp_t x;
        x = cnt_q.pop_front();
        checkOutput("bin", {28'd0, bin}, {28'd0, x.b});
        checkOutput("gray", {28'd0, gray}, {28'd0, x.g});
        checkOutput("wrap", {31'd0, wrap}, {31'd0, x.w});
    endtask

    // Match decoder output against queued expectations and their due edges.
    task automatic checkDecoder();
        dec_exp_t x;
        if (gdec_vld === 1'b1) begin
            if (dec_q.size() == 0) begin
                checkOutput("gdec_vld_spurious", {31'd0, gdec_vld}, 32'd0);
            end else begin
                x = dec_q.pop_front();
                checkOutput("gdec", {28'd0, gdec}, {28'd0, x.d});
                checkOutput("gdec_latency", edge_count, x.due);
            end
        end else if (dec_q.size() != 0 && dec_q[0].due <= edge_count) begin
            x = dec_q.pop_front();
            checkOutput("gdec_vld_missing", {31'd0, gdec_vld}, 32'd1);
        end
    endtask

    // Drive one cycle of inputs, record expectations, clock, then check.
    task automatic applyStimulus(input logic r, input logic e, input logic u,
                                 input logic l, input logic [WIDTH-1:0] lv,
                                 input logic gv, input logic [WIDTH-1:0] g);
        cnt_exp_t c;
        dec_exp_t d;
        rst      = r;
        en       = e;
        up       = u;
        load     = l;
        load_val = lv;
        gin_vld  = gv;
        gin      = g;
        modelCounter(r, e, u, l, lv);
        c.b = m_bin;
        c.g = toGray(m_bin);
        c.w = m_wrap;
        cnt_q.push_back(c);
        if (r) begin
            dec_q.delete();
        end else if (gv) begin
            d.due = edge_count + 2;
            d.d   = grayToBin(g);
            dec_q.push_back(d);
        end
        @(posedge clk);
        edge_count++;
        #1;
        checkCounter();
        checkDecoder();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        end
    endtask

    // Main sequence: directed cases from the test plan, then random traffic.
    initial begin
        logic [WIDTH-1:0] prev_gray;
        logic             r_r, r_e, r_u, r_l, r_gv;
        logic [WIDTH-1:0] r_lv, r_g;

        gray_seq[0]  = 4'b0000; gray_seq[1]  = 4'b0001; gray_seq[2]  = 4'b0011;
        gray_seq[3]  = 4'b0010; gray_seq[4]  = 4'b0110; gray_seq[5]  = 4'b0111;
        gray_seq[6]  = 4'b0101; gray_seq[7]  = 4'b0100; gray_seq[8]  = 4'b1100;
        gray_seq[9]  = 4'b1101; gray_seq[10] = 4'b1111; gray_seq[11] = 4'b1110;
        gray_seq[12] = 4'b1010; gray_seq[13] = 4'b1011; gray_seq[14] = 4'b1001;
        gray_seq[15] = 4'b1000; gray_seq[16] = 4'b0000;

        m_bin    = '0;
        m_wrap   = 1'b0;
        rst      = 1'b1;
        en       = 1'b0;
        up       = 1'b0;
        load     = 1'b0;
        load_val = '0;
        gin      = '0;
        gin_vld  = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        checkOutput("rst_gdec_vld", {31'd0, gdec_vld}, 32'd0);

        repeat (5) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        checkOutput("pre_rst_bin", {28'd0, bin}, 32'h5);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, 4'b1011);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1, 4'b0110);
        checkOutput("mid_rst_bin", {28'd0, bin}, 32'd0);
        idle(3);

        prev_gray = gray_seq[0];
        for (int k = 1; k <= TABLE_STEPS; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
            checkOutput("gray_seq", {28'd0, gray}, {28'd0, gray_seq[k]});
            checkOutput("gray_one_bit", $countones(gray ^ prev_gray), 32'd1);
            prev_gray = gray;
        end

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
`ifdef GRAY_COUNTER_SAT_EN
        checkOutput("down_sat_bin", {28'd0, bin}, 32'h0);
        checkOutput("down_sat_wrap", {31'd0, wrap}, 32'd1);
`else
        checkOutput("down_wrap_gray", {28'd0, gray}, 32'h8);
        checkOutput("down_wrap_flag", {31'd0, wrap}, 32'd1);
`endif
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        idle(1);

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'b1101, 1'b0, '0);
        checkOutput("load_gray", {28'd0, gray}, 32'hB);

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 4'b1011);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 4'b1000);
        checkOutput("dec_first", {28'd0, gdec}, 32'hD);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 4'b0110);
        idle(3);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, '0);
        repeat (3) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
`ifdef GRAY_COUNTER_SAT_EN
            checkOutput("sat_up_bin", {28'd0, bin}, 32'hF);
            checkOutput("sat_up_wrap", {31'd0, wrap}, 32'd1);
`endif
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);

        for (int i = 0; i < 300; i++) begin
            r_r  = ($urandom_range(0, 49) == 0);
            r_l  = ($urandom_range(0, 9) == 0);
            r_e  = ($urandom_range(0, 3) != 0);
            r_u  = 1'($urandom_range(0, 1));
            r_lv = 4'($urandom_range(0, 15));
            r_gv = 1'($urandom_range(0, 1));
            r_g  = 4'($urandom_range(0, 15));
            applyStimulus(r_r, r_e, r_u, r_l, r_lv, r_gv, r_g);
        end

        idle(4);
        checkOutput("dec_drain", dec_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
